// File: rtl/nibble_scatter4_if.sv
// Handshake/bus bundle for nibble_scatter4: nibble beats in, packed 32-bit word pair out.
interface nibble_scatter4_if #(
    parameter int LANES  = 4,
    parameter int WORD_W = 32,
    parameter int POS_W  = 3
);
    logic [4*LANES-1:0]     NIBBLE_IN;
    logic [LANES-1:0]       LANE_EN;
    logic [POS_W*LANES-1:0] sc_sel_A;
    logic [POS_W*LANES-1:0] sc_sel_B;
    logic [LANES-1:0]       sc_SEL;
    logic                   IN_VALID;
    logic                   IN_READY;
    logic                   FLUSH;
    logic [WORD_W-1:0]      DATA_A;
    logic [WORD_W-1:0]      DATA_B;
    logic [WORD_W/4-1:0]    MASK_A;
    logic [WORD_W/4-1:0]    MASK_B;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic                   COLLISION;

    modport master (
        output NIBBLE_IN, LANE_EN, sc_sel_A, sc_sel_B, sc_SEL, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, DATA_A, DATA_B, MASK_A, MASK_B, OUT_VALID, COLLISION
    );

    modport slave (
        input  NIBBLE_IN, LANE_EN, sc_sel_A, sc_sel_B, sc_SEL, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, DATA_A, DATA_B, MASK_A, MASK_B, OUT_VALID, COLLISION
    );
endinterface

// File: rtl/nibble_scatter4.sv
// Scatters per-lane nibbles into slots of two assembly words (A/B) and emits the pair
// once both words are complete or on FLUSH, using a FILL/HOLD valid-ready handshake.
module nibble_scatter4 #(
    parameter int LANES  = 4,
    parameter int WORD_W = 32,
    parameter int POS_W  = 3
) (
    input logic              CLK,
    input logic              RESET,
    nibble_scatter4_if.slave bus
);
    localparam int SLOTS = WORD_W / 4;

    typedef enum logic {FILL, HOLD} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] word_a, word_b, word_a_mg, word_b_mg, word_a_nx, word_b_nx;
    logic [SLOTS-1:0]  mask_a, mask_b, mask_a_mg, mask_b_mg, mask_a_nx, mask_b_nx;
    logic              collision, hit;
    logic              accept;

    function automatic logic [POS_W-1:0] lane_slot(
        input logic [POS_W*LANES-1:0] sel_a,
        input logic [POS_W*LANES-1:0] sel_b,
        input logic                   to_b,
        input int                     lane
    );
        return to_b ? sel_b[POS_W*lane +: POS_W] : sel_a[POS_W*lane +: POS_W];
    endfunction

    assign accept = bus.IN_VALID && (state == FILL);

    // Merge stage: lanes applied in ascending order so the highest enabled lane wins a shared slot.
    always_comb begin
        word_a_mg = word_a;
        word_b_mg = word_b;
        mask_a_mg = mask_a;
        mask_b_mg = mask_b;
        hit       = 1'b0;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.LANE_EN[i]) begin
                    if (bus.sc_SEL[i]) begin
                        word_b_mg[4*bus.sc_sel_B[POS_W*i +: POS_W] +: 4] = bus.NIBBLE_IN[4*i +: 4];
                        mask_b_mg[bus.sc_sel_B[POS_W*i +: POS_W]]        = 1'b1;
                    end else begin
                        word_a_mg[4*bus.sc_sel_A[POS_W*i +: POS_W] +: 4] = bus.NIBBLE_IN[4*i +: 4];
                        mask_a_mg[bus.sc_sel_A[POS_W*i +: POS_W]]        = 1'b1;
                    end
                end
            end
            for (int i = 0; i < LANES; i++) begin
                for (int j = i + 1; j < LANES; j++) begin
                    if (bus.LANE_EN[i] && bus.LANE_EN[j] && (bus.sc_SEL[i] == bus.sc_SEL[j]) &&
                        (lane_slot(bus.sc_sel_A, bus.sc_sel_B, bus.sc_SEL[i], i) ==
                         lane_slot(bus.sc_sel_A, bus.sc_sel_B, bus.sc_SEL[j], j))) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

    // Control stage: the emit decision looks at the post-merge masks, so a beat and FLUSH combine.
    always_comb begin
        state_nx  = state;
        word_a_nx = word_a_mg;
        word_b_nx = word_b_mg;
        mask_a_nx = mask_a_mg;
        mask_b_nx = mask_b_mg;
        case (state)
            FILL: begin
                if ((&mask_a_mg) && (&mask_b_mg)) begin
                    state_nx = HOLD;
                end else if (bus.FLUSH && ((|mask_a_mg) || (|mask_b_mg))) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (bus.OUT_READY) begin
                    state_nx  = FILL;
                    word_a_nx = '0;
                    word_b_nx = '0;
                    mask_a_nx = '0;
                    mask_b_nx = '0;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= FILL;
            word_a    <= '0;
            word_b    <= '0;
            mask_a    <= '0;
            mask_b    <= '0;
            collision <= 1'b0;
        end else begin
            state     <= state_nx;
            word_a    <= word_a_nx;
            word_b    <= word_b_nx;
            mask_a    <= mask_a_nx;
            mask_b    <= mask_b_nx;
            collision <= hit;
        end
    end

    assign bus.IN_READY  = (state == FILL);
    assign bus.OUT_VALID = (state == HOLD);
    assign bus.DATA_A    = word_a;
    assign bus.DATA_B    = word_b;
    assign bus.MASK_A    = mask_a;
    assign bus.MASK_B    = mask_b;
    assign bus.COLLISION = collision;
endmodule

// File: tb/tb_nibble_scatter4.sv
// Scoreboard bench for nibble_scatter4: expected emits queued as beats are driven, checked at HOLD.
module tb_nibble_scatter4;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  ma;
        logic [7:0]  mb;
    } exp_t;

    exp_t sb_q[$];

    nibble_scatter4_if bus ();

    nibble_scatter4 dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] ma, input logic [7:0] mb);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.ma = ma;
        e.mb = mb;
        sb_q.push_back(e);
    endtask

    task automatic beat(input logic [15:0] nib, input logic [3:0] en, input logic [11:0] sa,
                        input logic [11:0] sb, input logic [3:0] sel, input logic flush);
        bus.NIBBLE_IN = nib;
        bus.LANE_EN   = en;
        bus.sc_sel_A  = sa;
        bus.sc_sel_B  = sb;
        bus.sc_SEL    = sel;
        bus.IN_VALID  = 1'b1;
        bus.FLUSH     = flush;
        tick();
        bus.IN_VALID  = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.LANE_EN   = '0;
    endtask

    task automatic flush_only();
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
    endtask

    // lanes 0/1 fill A slots, lanes 2/3 fill B slots, nibbles 1..F,0 in order
    task automatic fill_pattern(input string tag);
        for (int k = 0; k < 4; k++) begin
            beat({4'(10 + 2*k), 4'(9 + 2*k), 4'(2 + 2*k), 4'(1 + 2*k)}, 4'b1111,
                 {3'd0, 3'd0, 3'(2*k + 1), 3'(2*k)},
                 {3'(2*k + 1), 3'(2*k), 3'd0, 3'd0}, 4'b1100, 1'b0);
            if (k < 3) chk({tag, "_fill_vld"}, 32'(bus.OUT_VALID), 32'd0);
            if (k == 0) chk({tag, "_nocoll"}, 32'(bus.COLLISION), 32'd0);
        end
        push_exp(32'h87654321, 32'h0FEDCBA9, 8'hFF, 8'hFF);
    endtask

    task automatic expect_emit(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.OUT_VALID && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_out_vld"}, 32'(bus.OUT_VALID), 32'd1);
        chk({tag, "_in_rdy"}, 32'(bus.IN_READY), 32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data_a"}, bus.DATA_A, e.a);
            chk({tag, "_data_b"}, bus.DATA_B, e.b);
            chk({tag, "_mask_a"}, 32'(bus.MASK_A), 32'(e.ma));
            chk({tag, "_mask_b"}, 32'(bus.MASK_B), 32'(e.mb));
        end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        chk({tag, "_post_vld"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, "_post_rdy"}, 32'(bus.IN_READY), 32'd1);
        chk({tag, "_post_ma"}, 32'(bus.MASK_A), 32'd0);
        chk({tag, "_post_mb"}, 32'(bus.MASK_B), 32'd0);
        chk({tag, "_post_da"}, bus.DATA_A, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        bus.NIBBLE_IN = '0;
        bus.LANE_EN   = '0;
        bus.sc_sel_A  = '0;
        bus.sc_sel_B  = '0;
        bus.sc_SEL    = '0;
        bus.IN_VALID  = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_out_vld", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_in_rdy", 32'(bus.IN_READY), 32'd1);
        chk("rst_data_a", bus.DATA_A, 32'd0);
        chk("rst_data_b", bus.DATA_B, 32'd0);
        chk("rst_mask_a", 32'(bus.MASK_A), 32'd0);
        chk("rst_mask_b", 32'(bus.MASK_B), 32'd0);
        chk("rst_coll", 32'(bus.COLLISION), 32'd0);
        rst = 1'b0;
        tick();

        // full fill of both words
        fill_pattern("full");
        expect_emit("full");

        // lanes 0 and 2 collide on A slot 5; lane 2 must win
        beat(16'h0903, 4'b0101, {3'd0, 3'd5, 3'd0, 3'd5}, 12'h000, 4'b0000, 1'b0);
        chk("coll_pulse", 32'(bus.COLLISION), 32'd1);
        chk("coll_nib", (bus.DATA_A >> 20) & 32'hF, 32'h9);
        tick();
        chk("coll_clear", 32'(bus.COLLISION), 32'd0);
        flush_only();
        push_exp(32'h00900000, 32'h0, 8'h20, 8'h00);
        expect_emit("coll");

        // single nibble then separate FLUSH
        beat(16'h000C, 4'b0001, 12'h000, 12'h000, 4'b0000, 1'b0);
        chk("part_vld", 32'(bus.OUT_VALID), 32'd0);
        flush_only();
        push_exp(32'h0000000C, 32'h0, 8'h01, 8'h00);
        expect_emit("part");

        // empty beat and FLUSH with nothing written are both no-ops
        beat(16'hFFFF, 4'b0000, 12'hFFF, 12'hFFF, 4'b1010, 1'b0);
        chk("empty_mask_a", 32'(bus.MASK_A), 32'd0);
        chk("empty_data_b", bus.DATA_B, 32'd0);
        flush_only();
        chk("flush_empty_vld", 32'(bus.OUT_VALID), 32'd0);
        chk("flush_empty_rdy", 32'(bus.IN_READY), 32'd1);

        // overwrite A slot 1, then a beat merged with FLUSH in the same cycle
        beat(16'h0002, 4'b0001, 12'h001, 12'h000, 4'b0000, 1'b0);
        beat(16'h00A7, 4'b0011, 12'h001, 12'h038, 4'b0010, 1'b1);
        push_exp(32'h00000070, 32'hA0000000, 8'h02, 8'h80);
        expect_emit("merge");

        // HOLD stability with OUT_READY low and IN_VALID pushing
        fill_pattern("stall");
        bus.NIBBLE_IN = 16'h5555;
        bus.LANE_EN   = 4'b1111;
        bus.sc_sel_A  = 12'h000;
        bus.sc_sel_B  = 12'h000;
        bus.sc_SEL    = 4'b0000;
        bus.IN_VALID  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_vld", 32'(bus.OUT_VALID), 32'd1);
            chk("stall_rdy", 32'(bus.IN_READY), 32'd0);
            chk("stall_da", bus.DATA_A, 32'h87654321);
            chk("stall_db", bus.DATA_B, 32'h0FEDCBA9);
        end
        bus.IN_VALID = 1'b0;
        bus.LANE_EN  = '0;
        expect_emit("stall");

        // reset during HOLD discards the held words
        beat(16'h0050, 4'b0010, 12'h000, 12'h010, 4'b0010, 1'b1);
        chk("hrst_pre_vld", 32'(bus.OUT_VALID), 32'd1);
        chk("hrst_pre_db", bus.DATA_B, 32'h00000500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hrst_vld", 32'(bus.OUT_VALID), 32'd0);
        chk("hrst_rdy", 32'(bus.IN_READY), 32'd1);
        chk("hrst_da", bus.DATA_A, 32'd0);
        chk("hrst_db", bus.DATA_B, 32'd0);
        chk("hrst_mb", 32'(bus.MASK_B), 32'd0);
        tick();

        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
